// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the FAULT state).
package fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEFAULT = PC_W'(32'h0000_0000);
  localparam logic [PC_W-1:0] PC_INCR              = PC_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    ST_FAULT = 3'd4
`endif
  } fetch_state_e;

  // Instruction payload handed to decode.
  typedef struct packed {
    logic              fault;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] data;
  } inst_pkt_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: redirect input, instruction-memory request/response
// channel and decode-side instruction handshake.
//   master: the fetch sequencer
//   slave : execute / memory / decode environment
interface fetch_sequencer_if import fetch_pkg::*; ();

  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_target;
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [PC_W-1:0]     imem_req_addr;
  logic                imem_resp_valid;
  logic [INST_W-1:0]   imem_resp_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_W-1:0]   inst_data;
  logic [PC_W-1:0]     inst_pc;
  logic                inst_fault;

  modport master (
    input  redirect_valid, redirect_target,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_ready,
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst_data, inst_pc, inst_fault
  );

  modport slave (
    output redirect_valid, redirect_target,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst_data, inst_pc, inst_fault
  );

endinterface

// File: rtl/fetch_sequencer_next_pc_sel.sv
// next_pc_sel: combinational next-PC priority mux (redirect > sequential > hold).
// Without FETCH_MISALIGN_TRAP_EN the redirect target is forced word-aligned;
// with it the raw target passes through so the sequencer can trap on it.
// Ports:
//   pc              current PC
//   redirect_valid  redirect request this cycle
//   redirect_target redirect destination
//   advance         sequential +4 step this cycle
//   next_pc_c       selected next PC
module next_pc_sel import fetch_pkg::*; (
  input  logic [PC_W-1:0] pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            advance,
  output logic [PC_W-1:0] next_pc_c
);

  logic [PC_W-1:0] target_c;

  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    target_c = redirect_target;
`else
    target_c = redirect_target & ~PC_W'(3);
`endif
    if (redirect_valid) begin
      next_pc_c = target_c;
    end else if (advance) begin
      next_pc_c = pc + PC_INCR;   // wraps modulo 2^32
    end else begin
      next_pc_c = pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues one instruction fetch at a time and
// buffers the returned instruction for decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// into FAULT instead of fetching; otherwise targets are word-aligned).
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   bus    fetch_sequencer_if.master (redirect, imem req/resp, inst out)
module fetch_sequencer import fetch_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;

  logic            req_valid_q, req_valid_d;
  logic [PC_W-1:0] req_addr_q, req_addr_d;
  logic            inst_valid_q, inst_valid_d;
  inst_pkt_t       inst_q, inst_d;

  logic            kill_eff_c;
  logic            advance_c;

  // A response in WAIT is discarded if a kill is pending or a redirect lands now.
  assign kill_eff_c = kill_q | bus.redirect_valid;
  assign advance_c  = (state_q == ST_WAIT) && bus.imem_resp_valid && !kill_eff_c;

  next_pc_sel u_next_pc_sel (
    .pc              (pc_q),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (bus.redirect_target),
    .advance         (advance_c),
    .next_pc_c       (pc_d)
  );

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_VECTOR;
      kill_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= RESET_VECTOR;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
    end
  end

  // Next-state and kill tracking.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // An unaccepted request stays presented; a redirect only poisons it.
        if (bus.redirect_valid) kill_d = 1'b1;
        if (bus.imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_resp_valid) begin
          kill_d  = 1'b0;
          state_d = kill_eff_c ? ST_REQ : ST_HOLD;
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_valid || (inst_valid_q && bus.inst_ready)) state_d = ST_REQ;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_FAULT: begin
        if (bus.redirect_valid)  state_d = ST_REQ;
        else if (bus.inst_ready) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    // Any fresh fetch of a misaligned PC becomes a fault instead.
    if ((state_d == ST_REQ) && (state_q != ST_REQ) && (pc_d[1:0] != 2'b00)) begin
      state_d = ST_FAULT;
    end
`endif
  end

  // Next values of the registered outputs.
  always_comb begin
    req_valid_d  = (state_d == ST_REQ);
    req_addr_d   = req_addr_q;
    inst_valid_d = (state_d == ST_HOLD);
    inst_d       = inst_q;
    // Latch the address only when a new request starts, keeping it stable until accepted.
    if ((state_d == ST_REQ) && (state_q != ST_REQ)) req_addr_d = pc_d;
    if (advance_c) begin
      inst_d.data  = bus.imem_resp_data;
      inst_d.pc    = pc_q;
      inst_d.fault = 1'b0;
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    if (state_d == ST_FAULT) begin
      inst_valid_d = 1'b1;
      inst_d.data  = '0;
      inst_d.pc    = pc_d;
      inst_d.fault = 1'b1;
    end else begin
      inst_d.fault = 1'b0;
    end
`endif
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = req_addr_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_data      = inst_q.data;
  assign bus.inst_pc        = inst_q.pc;
  assign bus.inst_fault     = inst_q.fault;

endmodule
